// File: rtl/serial_word_feeder_if.sv
// Handshake and serial-stream bundle for serial_word_feeder.
// The upstream word source uses the master modport; the feeder uses slave.
interface serial_word_feeder_if #(
    parameter int WIDTH = 8,
    parameter int IDXW  = $clog2(WIDTH)
);
    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             ser_out;
    logic             ser_valid;
    logic [IDXW-1:0]  bit_index;
    logic             word_done;
    logic             busy;

    modport master (
        output load_data,
        output load_valid,
        input  load_ready,
        input  ser_out,
        input  ser_valid,
        input  bit_index,
        input  word_done,
        input  busy
    );

    modport slave (
        input  load_data,
        input  load_valid,
        output load_ready,
        output ser_out,
        output ser_valid,
        output bit_index,
        output word_done,
        output busy
    );
endinterface

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder for the 11011 sequence detector.
// Words arrive over valid/ready and leave MSB first, one bit per clock.
// A one-entry holding register keeps the bit stream gap-free across
// word boundaries; a word offered in the last-bit cycle with the hold
// empty bypasses straight into the shift register.
module serial_word_feeder #(
    parameter int WIDTH = 8,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic                input_pulse,
    input  logic                clear,
    serial_word_feeder_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);
    localparam logic [IDXW-1:0] IDX_ZERO = IDXW'(0);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

    // Architectural state
    state_t           state_r;
    logic [WIDTH-1:0] sreg_r;
    logic [WIDTH-1:0] hold_r;
    logic             hold_full_r;
    logic [IDXW-1:0]  idx_r;

    // Registered outputs, loaded from the next-state values
    logic             ser_out_r;
    logic             ser_valid_r;
    logic             word_done_r;
    logic             busy_r;

    // Next-state values
    state_t           nxt_state_s;
    logic [WIDTH-1:0] nxt_sreg_s;
    logic [WIDTH-1:0] nxt_hold_s;
    logic             nxt_hold_full_s;
    logic [IDXW-1:0]  nxt_idx_s;

    logic             load_ready_s;
    logic             accept_s;

    // Ready must fall with clear so nothing is taken while in reset.
    assign load_ready_s   = clear && !hold_full_r;
    assign accept_s       = bus.load_valid && load_ready_s;

    assign bus.load_ready = load_ready_s;
    assign bus.ser_out    = ser_out_r;
    assign bus.ser_valid  = ser_valid_r;
    assign bus.bit_index  = idx_r;
    assign bus.word_done  = word_done_r;
    assign bus.busy       = busy_r;

    // Next-state logic: shift, refill from hold, bypass, or go idle.
    always_comb begin
        nxt_state_s     = state_r;
        nxt_sreg_s      = sreg_r;
        nxt_hold_s      = hold_r;
        nxt_hold_full_s = hold_full_r;
        nxt_idx_s       = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    nxt_sreg_s  = bus.load_data;
                    nxt_idx_s   = IDX_ZERO;
                    nxt_state_s = ST_SHIFT;
                end else begin
                    nxt_state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (idx_r != LAST_IDX) begin
                    nxt_sreg_s = {sreg_r[WIDTH-2:0], 1'b0};
                    nxt_idx_s  = idx_r + IDX_ONE;
                    if (accept_s) begin
                        nxt_hold_s      = bus.load_data;
                        nxt_hold_full_s = 1'b1;
                    end else begin
                        nxt_hold_full_s = hold_full_r;
                    end
                end else if (hold_full_r) begin
                    // Buffered word goes next; load_ready is low so
                    // nothing new can be accepted this cycle.
                    nxt_sreg_s      = hold_r;
                    nxt_hold_full_s = 1'b0;
                    nxt_idx_s       = IDX_ZERO;
                end else if (accept_s) begin
                    nxt_sreg_s = bus.load_data;
                    nxt_idx_s  = IDX_ZERO;
                end else begin
                    // Clearing sreg keeps ser_out at zero while idle.
                    nxt_sreg_s  = {WIDTH{1'b0}};
                    nxt_idx_s   = IDX_ZERO;
                    nxt_state_s = ST_IDLE;
                end
            end
            default: begin
                nxt_sreg_s      = {WIDTH{1'b0}};
                nxt_hold_full_s = 1'b0;
                nxt_idx_s       = IDX_ZERO;
                nxt_state_s     = ST_IDLE;
            end
        endcase
    end

    // State and output registers; clear discards any partial and held word.
    always_ff @(posedge input_pulse or negedge clear) begin
        if (!clear) begin
            state_r     <= ST_IDLE;
            sreg_r      <= {WIDTH{1'b0}};
            hold_r      <= {WIDTH{1'b0}};
            hold_full_r <= 1'b0;
            idx_r       <= IDX_ZERO;
            ser_out_r   <= 1'b0;
            ser_valid_r <= 1'b0;
            word_done_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= nxt_state_s;
            sreg_r      <= nxt_sreg_s;
            hold_r      <= nxt_hold_s;
            hold_full_r <= nxt_hold_full_s;
            idx_r       <= nxt_idx_s;
            ser_out_r   <= (nxt_state_s == ST_SHIFT) ? nxt_sreg_s[WIDTH-1] : 1'b0;
            ser_valid_r <= (nxt_state_s == ST_SHIFT);
            word_done_r <= (nxt_state_s == ST_SHIFT) && (nxt_idx_s == LAST_IDX);
            busy_r      <= (nxt_state_s == ST_SHIFT) || nxt_hold_full_s;
        end
    end

endmodule
